fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have ports: clk in 1, the single clock; resetn in 1, synchronous active-low reset.
REQ-002 SHALL have inst SRAM ports: inst_sram_en out 1; inst_sram_we out 4, tied 0; inst_sram_addr out 32; inst_sram_wdata out 32, tied 0; inst_sram_rdata in 32, valid 1 cycle after an enabled request.
REQ-003 SHALL have ID handshake ports: ds_allowin in 1; fs_to_ds_valid out 1; fs_pc out 32; fs_inst out 32, feeding decoder inst; fs_ex_adef out 1, fetch-address-error flag.
REQ-004 SHALL have redirect ports: br_taken in 1; br_target in 32; ex_flush in 1; ex_entry in 32; ertn_flush in 1; era in 32.

Function
REQ-005 SHALL hold state fs_valid and fs_pc; fs_ready_go SHALL be constant 1.
REQ-006 SHALL compute fs_allowin = !fs_valid || ds_allowin.
REQ-007 SHALL select nextpc by priority ex_flush > ertn_flush > br_taken > fs_pc+4, with addition modulo 2^32 (wrap 0xFFFFFFFC -> 0x00000000).
REQ-008 SHALL define redirect = ex_flush || ertn_flush || br_taken.
REQ-009 SHALL on redirect, regardless of ds_allowin: load fs_pc <= nextpc and fs_valid <= 1, and discard the instruction currently in FS (never presented to ID).
REQ-010 SHALL on no redirect with fs_allowin=1: load fs_pc <= nextpc and fs_valid <= 1.
REQ-011 SHALL otherwise hold fs_pc and fs_valid.
REQ-012 SHALL drive inst_sram_addr = {nextpc[31:2],2'b00} when loading, else {fs_pc[31:2],2'b00}.
REQ-013 SHALL drive fs_to_ds_valid = fs_valid && !redirect.
REQ-014 SHALL drive fs_pc = PC of the FS instruction.
REQ-015 SHALL drive fs_inst = the SRAM word for fs_pc; fs_inst SHALL be 0 when fs_ex_adef=1.
REQ-016 SHALL drive fs_ex_adef = fs_valid && (fs_pc[1:0] != 0).
REQ-017 SHALL NOT enable an SRAM request when the address being loaded has [1:0] != 0.
REQ-018 SHALL transfer exactly one instruction to ID per cycle in which fs_to_ds_valid && ds_allowin; no instruction SHALL be duplicated or dropped except on redirect.
REQ-019 SHALL on simultaneous ex_flush and br_taken use ex_entry; br_target SHALL be ignored.

Reset
REQ-020 SHALL while resetn=0 at a clk edge set fs_valid=0 and fs_pc=0x1BFFFFFC, so the first nextpc is 0x1C000000.
REQ-021 SHALL while resetn=0 force inst_sram_en=0, fs_to_ds_valid=0 and fs_ex_adef=0; any buffer state SHALL be cleared.
REQ-022 SHALL in the first cycle with resetn=1 issue a fetch of 0x1C000000 with inst_sram_en=1.
REQ-023 SHALL on reset asserted mid-stall discard the pending instruction; no handshake SHALL follow release until the refetch completes.

Configuration
REQ-024 SHALL use macro FS_INST_BUF_EN to select stall behaviour.
REQ-025 SHALL when FS_INST_BUF_EN is undefined: drive inst_sram_en = resetn && addr aligned every cycle; during a stall re-read fs_pc so rdata stays valid; fs_inst = inst_sram_rdata.
REQ-026 SHALL when FS_INST_BUF_EN is defined: keep a 1-entry buffer (inst_buf, buf_valid) that captures rdata in the first stall cycle (fs_valid && !ds_allowin && !buf_valid).
REQ-027 SHALL when FS_INST_BUF_EN is defined: drive inst_sram_en only when loading; fs_inst = buf_valid ? inst_buf : inst_sram_rdata.
REQ-028 SHALL when FS_INST_BUF_EN is defined: clear buf_valid on handshake or redirect.
REQ-029 SHALL keep ID-visible cycle behaviour identical with and without FS_INST_BUF_EN.

Verification
REQ-030 SHALL cover: reset release, ds_allowin=1 -> fetches 0x1C000000, 0x1C000004, 0x1C000008 on consecutive cycles, one fs_to_ds_valid per cycle.
REQ-031 SHALL cover: ds_allowin=0 for 3 cycles at fs_pc 0x1C000008 -> fs_pc and fs_inst stable; with macro, inst_sram_en=0 during cycles 2-3; 0x1C00000C fetched after release.
REQ-032 SHALL cover: br_taken=1, br_target=0x1C000100 while FS holds 0x1C000010 -> 0x1C000010 never handed to ID; next fs_pc=0x1C000100.
REQ-033 SHALL cover: ex_flush=1, ex_entry=0x1C008000, and br_taken=1 in the same cycle -> fs_pc=0x1C008000.
REQ-034 SHALL cover: ertn_flush=1, era=0x1C000042 -> fs_pc=0x1C000042, fs_ex_adef=1, fs_inst=0, no SRAM enable for that address.
REQ-035 SHALL cover: resetn=0 during a stall -> fs_to_ds_valid=0 next cycle; refetch starts at 0x1C000000.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of a single-issue pipeline.
//   Holds the PC of the instruction currently in FS, issues SRAM reads for the
//   next PC and hands instructions to the decode stage via a valid/allowin
//   handshake. Redirects (exception, exception return, branch) discard the
//   instruction currently in FS and restart fetch at the new target.
//
// Build option:
//   FS_INST_BUF_EN - when defined, a 1-entry buffer holds the fetched word
//                    during a stall so the SRAM is only enabled on PC loads.
//                    When undefined, the SRAM re-reads fs_pc every stall cycle.
//
// Ports:
//   clk, resetn          - clock, synchronous active-low reset
//   inst_sram_en/we/addr/wdata, inst_sram_rdata
//                        - instruction SRAM (read-only use, 1-cycle latency)
//   ds_allowin           - decode stage can accept an instruction
//   fs_to_ds_valid       - FS presents an instruction to decode
//   fs_pc, fs_inst       - PC and instruction word of the FS instruction
//   fs_ex_adef           - fetch address error (PC not word aligned)
//   br_taken/br_target   - branch redirect
//   ex_flush/ex_entry    - exception redirect (highest priority)
//   ertn_flush/era       - exception-return redirect
module fetch_stage (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_ex_adef,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ex_flush,
  input  logic [31:0] ex_entry,
  input  logic        ertn_flush,
  input  logic [31:0] era
);

  localparam logic [31:0] RESET_PC = 32'h1BFF_FFFC;

  logic        fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        redirect;
  logic        load;
  logic [31:0] nextpc;
  logic [31:0] addr_src;
  logic        pc_misaligned;
  logic [31:0] raw_inst;

  assign fs_ready_go = 1'b1;
  assign fs_allowin  = !fs_valid || (fs_ready_go && ds_allowin);
  assign redirect    = ex_flush || ertn_flush || br_taken;
  assign load        = redirect || fs_allowin;

  always_comb begin
    nextpc = fs_pc + 32'd4;
    if (ex_flush) begin
      nextpc = ex_entry;
    end else if (ertn_flush) begin
      nextpc = era;
    end else if (br_taken) begin
      nextpc = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC;
    end else if (load) begin
      fs_valid <= 1'b1;
      fs_pc    <= nextpc;
    end
  end

  assign addr_src        = load ? nextpc : fs_pc;
  assign inst_sram_addr  = {addr_src[31:2], 2'b00};
  assign inst_sram_we    = '0;
  assign inst_sram_wdata = '0;

  assign pc_misaligned  = fs_valid && (fs_pc[1:0] != 2'b00);
  assign fs_ex_adef     = resetn && pc_misaligned;
  assign fs_to_ds_valid = resetn && fs_valid && fs_ready_go && !redirect;
  assign fs_inst        = pc_misaligned ? '0 : raw_inst;

`ifdef FS_INST_BUF_EN
  logic [31:0] inst_buf;
  logic        buf_valid;
  logic        handshake;

  assign handshake    = fs_to_ds_valid && ds_allowin;
  // Only PC loads touch the SRAM; a stall is served from the buffer.
  assign inst_sram_en = resetn && load && (nextpc[1:0] == 2'b00);
  assign raw_inst     = buf_valid ? inst_buf : inst_sram_rdata;

  // rdata is still valid in the first stall cycle (it belongs to the load of
  // the previous cycle); capture it then. Clearing wins over capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      inst_buf  <= '0;
    end else if (redirect || handshake) begin
      buf_valid <= 1'b0;
    end else if (fs_valid && !ds_allowin && !buf_valid) begin
      buf_valid <= 1'b1;
      inst_buf  <= inst_sram_rdata;
    end
  end
`else
  // During a stall addr_src is fs_pc, so the SRAM keeps re-reading the held
  // instruction and rdata stays valid without any local storage.
  assign inst_sram_en = resetn && (addr_src[1:0] == 2'b00);
  assign raw_inst     = inst_sram_rdata;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a cycle model of the
// fetch PC stream, a 1-cycle-latency SRAM model and a log of handed-over PCs.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_ex_adef;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ex_flush;
  logic [31:0] ex_entry;
  logic        ertn_flush;
  logic [31:0] era;

  int unsigned errors = 0;
  int unsigned checks = 0;

  fetch_stage dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .ds_allowin(ds_allowin), .fs_to_ds_valid(fs_to_ds_valid),
    .fs_pc(fs_pc), .fs_inst(fs_inst), .fs_ex_adef(fs_ex_adef),
    .br_taken(br_taken), .br_target(br_target),
    .ex_flush(ex_flush), .ex_entry(ex_entry),
    .ertn_flush(ertn_flush), .era(era)
  );

  always #5 clk = ~clk;

  // Memory image: each word is a fixed scramble of its own address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reads return data one cycle after an enabled request; anything else is junk.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= word(inst_sram_addr);
    else              inst_sram_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_valid;
  logic [31:0] m_pc;
  bit          model_ok = 0;
  logic [31:0] handed[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] target(input logic [31:0] pc);
    if (ex_flush)   return ex_entry;
    if (ertn_flush) return era;
    if (br_taken)   return br_target;
    return pc + 32'd4;
  endfunction

  function automatic bit redir();
    return ex_flush || ertn_flush || br_taken;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_valid  = 1'b0;
      m_pc     = 32'h1BFF_FFFC;
      model_ok = 1;
    end else if (model_ok && (redir() || !m_valid || ds_allowin)) begin
      m_pc    = target(m_pc);
      m_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      logic        loading;
      logic [31:0] want_addr;
      logic        want_en;
      loading   = redir() || !m_valid || ds_allowin;
      want_addr = loading ? target(m_pc) : m_pc;
`ifdef FS_INST_BUF_EN
      want_en = resetn && loading && (want_addr[1:0] == 2'b00);
`else
      want_en = resetn && (want_addr[1:0] == 2'b00);
`endif
      chk("m_we", {28'd0, inst_sram_we}, 32'd0);
      chk("m_wdata", inst_sram_wdata, 32'd0);
      chk("m_to_ds_valid", {31'd0, fs_to_ds_valid}, {31'd0, resetn && m_valid && !redir()});
      chk("m_en", {31'd0, inst_sram_en}, {31'd0, want_en});
      if (want_en) chk("m_addr", inst_sram_addr, want_addr & 32'hFFFF_FFFC);
      if (resetn) begin
        chk("m_pc", fs_pc, m_pc);
        chk("m_adef", {31'd0, fs_ex_adef}, {31'd0, m_valid && (m_pc[1:0] != 2'b00)});
        if (m_valid) chk("m_inst", fs_inst, (m_pc[1:0] != 2'b00) ? 32'd0 : word(m_pc));
      end else begin
        chk("m_adef_rst", {31'd0, fs_ex_adef}, 32'd0);
      end
      if (fs_to_ds_valid && ds_allowin) handed.push_back(fs_pc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_handed(input string name);
    chk({name, "_len"}, handed.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < handed.size(); i++)
      chk(name, handed[i], exp_q[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    resetn = 0; ds_allowin = 1;
    br_taken = 0; br_target = '0; ex_flush = 0; ex_entry = '0;
    ertn_flush = 0; era = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_en", {31'd0, inst_sram_en}, 32'd0);
      chk("rst_to_ds", {31'd0, fs_to_ds_valid}, 32'd0);
      chk("rst_adef", {31'd0, fs_ex_adef}, 32'd0);
    end
    step();
    chk("rst_pc", fs_pc, 32'h1BFF_FFFC);
    resetn = 1;                                   // C0
    @(negedge clk);
    chk("first_en", {31'd0, inst_sram_en}, 32'd1);
    chk("first_addr", inst_sram_addr, 32'h1C00_0000);
    chk("first_to_ds", {31'd0, fs_to_ds_valid}, 32'd0);
    step();                                       // C1
    step();                                       // C2
    step(); ds_allowin = 0;                       // C3..C5 stall at 0x1C000008
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_pc", fs_pc, 32'h1C00_0008);
      chk("stall_inst", fs_inst, 32'h135F_87DF);
      chk("stall_to_ds", {31'd0, fs_to_ds_valid}, 32'd1);
`ifdef FS_INST_BUF_EN
      if (i > 0) chk("stall_en", {31'd0, inst_sram_en}, 32'd0);
`endif
      step();
    end
    ds_allowin = 1;                               // C6
    @(negedge clk);
    chk("release_addr", inst_sram_addr, 32'h1C00_000C);
    chk("release_en", {31'd0, inst_sram_en}, 32'd1);
    step();                                       // C7
    step();                                       // C8: branch while FS holds 0x1C000010
    br_taken = 1; br_target = 32'h1C00_0100;
    @(negedge clk);
    chk("br_cur_pc", fs_pc, 32'h1C00_0010);
    chk("br_to_ds", {31'd0, fs_to_ds_valid}, 32'd0);
    step(); br_taken = 0;                         // C9
    @(negedge clk);
    chk("br_new_pc", fs_pc, 32'h1C00_0100);
    step();                                       // C10: exception beats branch
    exp_q = '{32'h1C00_0000, 32'h1C00_0004, 32'h1C00_0008, 32'h1C00_000C, 32'h1C00_0100};
    check_handed("handed_a");
    ex_flush = 1; ex_entry = 32'h1C00_8000; br_taken = 1; br_target = 32'h1C00_0200;
    step(); ex_flush = 0; br_taken = 0;           // C11
    @(negedge clk);
    chk("ex_pc", fs_pc, 32'h1C00_8000);
    step();                                       // C12: return to misaligned era
    ertn_flush = 1; era = 32'h1C00_0042;
    @(negedge clk);
    chk("ertn_en", {31'd0, inst_sram_en}, 32'd0);
    step(); ertn_flush = 0;                       // C13
    @(negedge clk);
    chk("adef_pc", fs_pc, 32'h1C00_0042);
    chk("adef_flag", {31'd0, fs_ex_adef}, 32'd1);
    chk("adef_inst", fs_inst, 32'd0);
    step();                                       // C14
    br_taken = 1; br_target = 32'h1C00_0300;
    @(negedge clk);
    chk("br2_addr", inst_sram_addr, 32'h1C00_0300);
    step(); br_taken = 0; ds_allowin = 0;         // C15, C16 stall
    step();
    step(); resetn = 0;                           // C17: reset during stall
    @(negedge clk);
    chk("rst_stall_to_ds", {31'd0, fs_to_ds_valid}, 32'd0);
    step(); resetn = 1; ds_allowin = 1;           // C18
    @(negedge clk);
    chk("refetch_to_ds", {31'd0, fs_to_ds_valid}, 32'd0);
    chk("refetch_addr", inst_sram_addr, 32'h1C00_0000);
    step();                                       // C19
    @(negedge clk);
    chk("refetch_pc", fs_pc, 32'h1C00_0000);
    step();                                       // C20: branch to top of memory
    br_taken = 1; br_target = 32'hFFFF_FFFC;
    step(); br_taken = 0;                         // C21
    @(negedge clk);
    chk("wrap_pc", fs_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", inst_sram_addr, 32'h0000_0000);
    step(); ds_allowin = 0;                       // C22, C23 stall at 0
    step();
    step(); br_taken = 1; br_target = 32'h1C00_0020; // C24: redirect while stalled
    @(negedge clk);
    chk("stall_br_to_ds", {31'd0, fs_to_ds_valid}, 32'd0);
    step(); br_taken = 0;                         // C25 stall on fresh target
    step(); ds_allowin = 1;                       // C26
    step();                                       // C27
    step();
    exp_q = '{32'h1C00_0000, 32'h1C00_0004, 32'h1C00_0008, 32'h1C00_000C,
              32'h1C00_0100, 32'h1C00_8000, 32'h1C00_0042, 32'h1C00_0000,
              32'hFFFF_FFFC, 32'h1C00_0020, 32'h1C00_0024};
    check_handed("handed_b");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
